// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: FSM states, ALUop codes and
// instruction field layout {op, cmp, rd, rn, rm}.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MOV = 2'b11
  } alu_op_t;

  // Register-index fields start at slot*r; cmp is the single bit at
  // CMP_SLOT*r, and op sits directly above cmp.
  localparam int RM_SLOT  = 0;
  localparam int RN_SLOT  = 1;
  localparam int RD_SLOT  = 2;
  localparam int CMP_SLOT = 3;

endpackage

// File: rtl/alu_seq_decode.sv
// Moore output decode: state + IR -> datapath enables, selects and indices.
// Reset forces every enable and index low.
module alu_seq_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int n = 2,
  parameter int r = 3
) (
  input  state_t           state,
  input  logic [n+3*r:0]   ir,
  input  logic             reset,
  output logic [r-1:0]     readnum,
  output logic [r-1:0]     writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic [n-1:0]     ALUop,
  output logic             w,
  output logic             done
);

  always_comb begin
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    ALUop    = '0;
    w        = 1'b0;
    done     = 1'b0;
    if (!reset) begin
      ALUop = ir[CMP_SLOT*r+1 +: n];
      case (state)
        IDLE:   w = 1'b1;
        LOAD_A: begin
          readnum = ir[RN_SLOT*r +: r];
          loada   = 1'b1;
        end
        LOAD_B: begin
          readnum = ir[RM_SLOT*r +: r];
          loadb   = 1'b1;
        end
        EXEC: begin
          loadc = 1'b1;
          loads = 1'b1;
          done  = ir[CMP_SLOT*r];
        end
        WRITE: begin
          writenum = ir[RD_SLOT*r +: r];
          write    = 1'b1;
          done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the Lab 5 datapath: accepts one instruction
// per handshake and walks it through read A/B, execute and writeback.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int n     = 2,
  parameter int r     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [n+3*r:0]   instr,
  input  logic             status_in,
  output logic [r-1:0]     readnum,
  output logic [r-1:0]     writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic [n-1:0]     ALUop,
  output logic             w,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  state_t         state;
  logic [n+3*r:0] ir;
  logic           status_unused;

  // The zero flag is consumed by the status register, not by this controller.
  assign status_unused = status_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      op_count <= '0;
    end else begin
      if (done) op_count <= op_count + 1'b1;
      case (state)
        IDLE: if (start) begin
          ir    <= instr;
          state <= LOAD_A;
        end
        // MOV has a single operand, so the B read is skipped.
        LOAD_A:  state <= (ir[CMP_SLOT*r+1 +: n] == n'(ALU_MOV)) ? EXEC : LOAD_B;
        LOAD_B:  state <= EXEC;
        EXEC:    state <= ir[CMP_SLOT*r] ? IDLE : WRITE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  alu_seq_decode #(.n(n), .r(r)) u_decode (
    .state    (state),
    .ir       (ir),
    .reset    (reset),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .ALUop    (ALUop),
    .w        (w),
    .done     (done)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed and random instructions
// compared cycle by cycle against a micro-step list built from the ISA rules.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [11:0] instr;
  logic       status_in;
  logic [2:0] readnum, writenum;
  logic       write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [1:0] ALUop;
  logic       w, done;
  logic [7:0] op_count;

  alu_op_sequencer #(.n(2), .r(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .status_in(status_in),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .ALUop(ALUop), .w(w), .done(done), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Enable vector order: {w, done, write, loada, loadb, loadc, loads, asel, bsel, vsel}
  localparam logic [9:0] E_W = 10'h200, E_DONE = 10'h100, E_WRITE = 10'h080,
                         E_LOADA = 10'h040, E_LOADB = 10'h020, E_LOADC = 10'h010,
                         E_LOADS = 10'h008;

  logic [9:0] en_obs;
  assign en_obs = {w, done, write, loada, loadb, loadc, loads, asel, bsel, vsel};

  typedef struct packed {
    logic [9:0] en;
    logic       rd_care;
    logic [2:0] rnum;
    logic       wr_care;
    logic [2:0] wnum;
    logic       op_care;
    logic [1:0] op;
  } step_t;

  step_t      exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cnt_model = 8'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the cycle list an instruction must produce after accept.
  task automatic build(input logic [11:0] ins);
    logic [1:0] op;
    logic       cmp;
    logic [2:0] rd, rn, rm;
    step_t      s;
    {op, cmp, rd, rn, rm} = ins;
    exp_q.delete();
    s = '0; s.en = E_LOADA; s.rd_care = 1'b1; s.rnum = rn; exp_q.push_back(s);
    if (op != 2'b11) begin
      s = '0; s.en = E_LOADB; s.rd_care = 1'b1; s.rnum = rm; exp_q.push_back(s);
    end
    s = '0; s.en = E_LOADC | E_LOADS | (cmp ? E_DONE : 10'h0);
    s.op_care = 1'b1; s.op = op; exp_q.push_back(s);
    if (!cmp) begin
      s = '0; s.en = E_WRITE | E_DONE; s.wr_care = 1'b1; s.wnum = rd; exp_q.push_back(s);
    end
  endtask

  task automatic chk_step(input string tag, input step_t s);
    chk({tag, ".en"}, 32'(en_obs), 32'(s.en));
    if (s.rd_care) chk({tag, ".readnum"}, 32'(readnum), 32'(s.rnum));
    if (s.wr_care) chk({tag, ".writenum"}, 32'(writenum), 32'(s.wnum));
    if (s.op_care) chk({tag, ".ALUop"}, 32'(ALUop), 32'(s.op));
  endtask

  // Called at an IDLE sample point; returns at the following IDLE sample point.
  task automatic run_instr(input string tag, input logic [11:0] ins, input bit hold);
    chk({tag, ".idle_w"}, 32'(w), 32'd1);
    build(ins);
    instr = ins;
    start = 1'b1;
    tick();
    foreach (exp_q[i]) begin
      chk_step($sformatf("%s.c%0d", tag, i), exp_q[i]);
      // Busy-time start/instr activity must not disturb the captured IR.
      instr = 12'($urandom);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    start = hold;
    cnt_model = cnt_model + 8'd1;
    chk({tag, ".after_en"}, 32'(en_obs), 32'(E_W));
    chk({tag, ".op_count"}, 32'(op_count), 32'(cnt_model));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; instr = 12'h0; status_in = 1'b0;
    repeat (2) tick();
    chk("rst.en", 32'(en_obs), 32'd0);
    chk("rst.idx", 32'({readnum, writenum, ALUop}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.en", 32'(en_obs), 32'(E_W));
    chk("post_rst.op_count", 32'(op_count), 32'd0);
    tick();

    // Directed: ADD r3 = r1 + r2, MOV r5 = r4, CMP r0 - r6.
    run_instr("add", {2'b00, 1'b0, 3'd3, 3'd1, 3'd2}, 1'b0);
    chk("add.latency", 32'(exp_q.size()), 32'd4);
    run_instr("mov", {2'b11, 1'b0, 3'd5, 3'd4, 3'd7}, 1'b0);
    chk("mov.latency", 32'(exp_q.size()), 32'd3);
    run_instr("cmp", {2'b01, 1'b1, 3'd7, 3'd0, 3'd6}, 1'b0);
    run_instr("same_reg", {2'b10, 1'b0, 3'd2, 3'd2, 3'd2}, 1'b0);
    run_instr("tst_mov", {2'b11, 1'b1, 3'd1, 3'd6, 3'd0}, 1'b0);

    // Busy start during LOAD_B, then reset in EXEC.
    build({2'b00, 1'b0, 3'd3, 3'd1, 3'd2});
    instr = {2'b00, 1'b0, 3'd3, 3'd1, 3'd2};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_step("rst_exec.c0", exp_q[0]);
    tick();
    chk_step("rst_exec.c1", exp_q[1]);
    start = 1'b1;
    instr = {2'b11, 1'b0, 3'd6, 3'd5, 3'd4};
    tick();
    start = 1'b0;
    chk_step("rst_exec.c2", exp_q[2]);
    reset = 1'b1;
    #1;
    chk("rst_exec.forced_en", 32'(en_obs), 32'd0);
    chk("rst_exec.forced_idx", 32'({readnum, writenum, ALUop}), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    cnt_model = 8'd0;
    chk("rst_exec.idle_en", 32'(en_obs), 32'(E_W));
    chk("rst_exec.op_count", 32'(op_count), 32'd0);
    tick();

    // Random instructions with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      run_instr($sformatf("rnd%0d", k), 12'($urandom), 1'b0);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk($sformatf("rnd%0d.gap", k), 32'(en_obs), 32'(E_W));
      end
    end

    // Wrap: 256 back-to-back ANDs with start held high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    cnt_model = 8'd0;
    for (int k = 0; k < 256; k++)
      run_instr("wrap", {2'b10, 1'b0, 9'($urandom)}, 1'b1);
    start = 1'b0;
    chk("wrap.op_count", 32'(op_count), 32'd0);
    tick();
    chk("wrap.idle_hold", 32'(en_obs), 32'(E_W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
